instr_mem_resp: RTL and testbench
=================================

INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default `ADDR_W, meaning byte-address width of i_pc, o_instr_addr and i_ld_addr.
REQ-002 SHALL have parameter INSTR_W, default `INSTR_W, meaning instruction width in bits; word stride = INSTR_W/8 bytes.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of instruction words stored.
REQ-004 SHALL have parameter LATENCY, default 2, legal range 1..4, meaning cycles from request acceptance to response.
REQ-005 SHALL have parameter NOP, default 32'h00000013, meaning instruction returned on fault.
REQ-006 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock, all state on rising edge.
- clr_n, in, 1, asynchronous active-low reset.
- i_pc, in, ADDR_W, fetch byte address.
- i_instr_req, in, 1, fetch request, accepted on any edge where i_hold=0.
- i_flush, in, 1, kill all in-flight requests (branch redirect).
- i_hold, in, 1, downstream stall; freezes response pipeline.
- i_ld_en, in, 1, program-load write enable.
- i_ld_addr, in, ADDR_W, load byte address.
- i_ld_data, in, INSTR_W, load word.
- o_instr, out, INSTR_W, returned instruction.
- o_instr_addr, out, ADDR_W, byte address of o_instr.
- o_instr_valid, out, 1, response valid, one cycle per accepted request.
- o_fault, out, 1, response is misaligned or out of range; qualified by o_instr_valid.
- o_stall, out, 1, request not accepted this cycle.

Function
REQ-007 SHALL implement a LATENCY-stage shift pipeline, each stage holding valid bit and address.
REQ-008 SHALL accept a request on a rising edge when i_instr_req=1 and i_hold=0, loading stage 0 with valid=1 and i_pc.
REQ-009 SHALL drive o_stall = i_hold combinationally; requests presented while i_hold=1 are ignored, not queued.
REQ-010 SHALL, with i_hold=0, advance all stages one position per edge; an edge with no accepted request loads stage 0 with valid=0.
REQ-011 SHALL, with i_hold=1, hold every stage and all outputs unchanged.
REQ-012 SHALL register outputs: o_instr_valid asserts exactly LATENCY edges after acceptance when no hold intervenes; each hold cycle adds one cycle.
REQ-013 SHALL compute word index = i_pc / (INSTR_W/8); read memory at the edge that loads the output registers.
REQ-014 SHALL set o_fault=1 and o_instr=NOP when the address has nonzero low log2(INSTR_W/8) bits or word index >= DEPTH; otherwise o_fault=0 and o_instr=memory word.
REQ-015 SHALL set o_instr_addr to the request address for every valid response, faulting or not.
REQ-016 SHALL, on an edge with i_flush=1, clear valid in every in-flight stage and the output register; a request accepted on the same edge SHALL be kept (new path).
REQ-017 SHALL give i_flush priority over i_hold: flush clears valids even while held.
REQ-018 SHALL write i_ld_data to word i_ld_addr/(INSTR_W/8) on edges with i_ld_en=1, regardless of i_hold; misaligned or out-of-range load writes SHALL be dropped.
REQ-019 SHALL return old memory contents when a read and a write hit the same word on the same edge.
REQ-020 SHALL never emit more than one response per cycle nor emit a response for an unaccepted or flushed request.

Reset
REQ-021 SHALL, on clr_n low, asynchronously clear all stage valids, o_instr_valid=0, o_fault=0, o_instr=0, o_instr_addr=0; memory contents SHALL NOT be reset.
REQ-022 SHALL discard in-flight requests on reset asserted mid-operation; the first response after release requires a new request.

Verification
REQ-023 Load word 0x00A00093 at addr 0x8, LATENCY=2, request pc=0x8 at edge N -> o_instr_valid=1, o_instr=0x00A00093, o_instr_addr=0x8, o_fault=0 after edge N+2.
REQ-024 Back-to-back requests 0x0,0x4,0x8 on consecutive edges -> three consecutive valid responses in order, no gaps.
REQ-025 Request 0x4 then i_flush=1 with request 0x40 on next edge -> no response for 0x4; response for 0x40 two edges later.
REQ-026 Request pc=0x6, and pc=DEPTH*4 -> each response o_fault=1, o_instr=0x00000013.
REQ-027 i_hold=1 for 3 cycles with one request in flight -> o_stall=1 throughout, response delayed by 3 cycles, new requests during hold produce no response.
REQ-028 clr_n pulsed low between request and response -> outputs zero immediately, no response after release.

Source files
------------

// File: rtl/instr_mem_resp.sv
// Instruction memory with a fixed-latency response pipeline that can be held
// and flushed, plus a program-load write port sharing the same storage.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef INSTR_W
`define INSTR_W 32
`endif

module instr_mem_resp #(
    parameter int                 ADDR_W  = `ADDR_W,
    parameter int                 INSTR_W = `INSTR_W,
    parameter int                 DEPTH   = 256,
    parameter int                 LATENCY = 2,
    parameter logic [INSTR_W-1:0] NOP     = 32'h00000013
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic               i_instr_req,
    input  logic               i_flush,
    input  logic               i_hold,
    input  logic               i_ld_en,
    input  logic [ADDR_W-1:0]  i_ld_addr,
    input  logic [INSTR_W-1:0] i_ld_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_addr,
    output logic               o_instr_valid,
    output logic               o_fault,
    output logic               o_stall
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(INSTR_W / 8);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    // Misaligned or beyond the last stored word.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        return ((a % STRIDE_A) != '0) || ((a / STRIDE_A) >= DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a / STRIDE_A);
    endfunction

    logic accept;
    assign accept  = i_instr_req & ~i_hold;
    assign o_stall = i_hold;

    // ------------------------------------------------------------------
    // Storage and program-load port
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic               ld_ok;
    assign ld_ok = i_ld_en & ~addr_fault(i_ld_addr);

    // NOTE: the storage array has no reset; clearing it would turn a RAM into
    // thousands of resettable flops, and program contents must survive clr_n.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem_q[word_idx(i_ld_addr)] <= i_ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Request pipeline: LATENCY stages of {valid, addr}
    // ------------------------------------------------------------------
    logic [LATENCY-1:0]             stg_valid_q, stg_valid_d;
    logic [LATENCY-1:0][ADDR_W-1:0] stg_addr_q,  stg_addr_d;

    // NOTE: every signal gets its hold value first so no path through this
    // block leaves it unassigned, which would infer a latch.
    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_addr_d  = stg_addr_q;
        if (!i_hold) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                stg_valid_d[i] = stg_valid_q[i-1];
                stg_addr_d[i]  = stg_addr_q[i-1];
            end
            stg_valid_d[0] = accept;
            stg_addr_d[0]  = i_pc;
        end
        // A redirect kills everything older but keeps the request that
        // arrives with it (accept is already low while held).
        if (i_flush) begin
            stg_valid_d    = '0;
            stg_valid_d[0] = accept;
        end
    end

    // ------------------------------------------------------------------
    // Output register, loaded from the last stage with the memory read
    // ------------------------------------------------------------------
    logic               src_valid;
    logic [ADDR_W-1:0]  src_addr;
    logic [INSTR_W-1:0] rd_data;

    assign src_valid = stg_valid_q[LATENCY-1] & ~i_flush;
    assign src_addr  = stg_addr_q[LATENCY-1];
    // Combinational read sampled at the same edge as any write: old data wins.
    assign rd_data   = mem_q[word_idx(src_addr)];

    logic               valid_q, valid_d;
    logic               fault_q, fault_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        if (!i_hold) begin
            valid_d = src_valid;
            if (src_valid) begin
                addr_d  = src_addr;
                fault_d = addr_fault(src_addr);
                instr_d = fault_d ? NOP : rd_data;
            end
        end else if (i_flush) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbours, regardless of statement order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stg_valid_q <= '0;
            stg_addr_q  <= '0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            addr_q      <= '0;
            instr_q     <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_addr_q  <= stg_addr_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
        end
    end

    assign o_instr_valid = valid_q;
    assign o_fault       = fault_q;
    assign o_instr_addr  = addr_q;
    assign o_instr       = instr_q;

endmodule

// File: tb/tb_instr_mem_resp.sv
// Randomized bench for instr_mem_resp: a tagged request queue counts unheld
// edges to decide when each surviving request must appear at the output.
module tb_instr_mem_resp;

    localparam int          ADDR_W  = 32;
    localparam int          INSTR_W = 32;
    localparam int          DEPTH   = 256;
    localparam int          LATENCY = 2;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [31:0] i_pc, i_ld_addr, i_ld_data;
    logic        i_instr_req, i_flush, i_hold, i_ld_en;
    logic [31:0] o_instr, o_instr_addr;
    logic        o_instr_valid, o_fault, o_stall;

    always #5 clk = ~clk;

    instr_mem_resp #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY),
        .NOP    (NOP)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .i_pc         (i_pc),
        .i_instr_req  (i_instr_req),
        .i_flush      (i_flush),
        .i_hold       (i_hold),
        .i_ld_en      (i_ld_en),
        .i_ld_addr    (i_ld_addr),
        .i_ld_data    (i_ld_data),
        .o_instr      (o_instr),
        .o_instr_addr (o_instr_addr),
        .o_instr_valid(o_instr_valid),
        .o_fault      (o_fault),
        .o_stall      (o_stall)
    );

    // Reference model state
    typedef struct {
        int unsigned tag;
        logic [31:0] addr;
    } req_t;

    req_t        q[$];
    int unsigned tick;
    logic [31:0] mem_m [DEPTH];
    logic        m_valid, m_fault;
    logic [31:0] m_addr, m_instr;

    int checks = 0;
    int errors = 0;

    // Stimulus for the next step
    logic        d_req, d_flush, d_hold, d_ld_en;
    logic [31:0] d_pc, d_ld_addr, d_ld_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    // One rising edge of the specified behaviour, using the inputs now driven.
    task automatic model_edge();
        if (i_flush) begin
            q.delete();
            m_valid = 1'b0;
        end
        if (!i_hold) begin
            tick++;
            if (i_instr_req) q.push_back('{tick, i_pc});
            m_valid = 1'b0;
            if (q.size() > 0 && q[0].tag + LATENCY == tick) begin
                m_valid = 1'b1;
                m_addr  = q[0].addr;
                m_fault = m_is_fault(q[0].addr);
                if (m_fault) m_instr = NOP;
                else         m_instr = mem_m[q[0].addr >> 2];
                void'(q.pop_front());
            end
        end
        if (i_ld_en && !m_is_fault(i_ld_addr)) mem_m[i_ld_addr >> 2] = i_ld_data;
    endtask

    task automatic compare();
        check("o_instr_valid", o_instr_valid, m_valid);
        if (m_valid) begin
            check("o_instr_addr", o_instr_addr, m_addr);
            check("o_fault", o_fault, m_fault);
            check("o_instr", o_instr, m_instr);
        end
    endtask

    task automatic clear_stim();
        d_req = 0; d_flush = 0; d_hold = 0; d_ld_en = 0;
        d_pc = '0; d_ld_addr = '0; d_ld_data = '0;
    endtask

    task automatic step();
        @(negedge clk);
        i_instr_req = d_req;  i_pc      = d_pc;
        i_flush     = d_flush; i_hold   = d_hold;
        i_ld_en     = d_ld_en; i_ld_addr = d_ld_addr; i_ld_data = d_ld_data;
        #1 check("o_stall", o_stall, d_hold);
        model_edge();
        @(posedge clk);
        #1 compare();
        clear_stim();
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_instr_req = 0; i_flush = 0; i_hold = 0; i_ld_en = 0;
        clr_n = 1'b0;
        q.delete();
        m_valid = 0; m_fault = 0; m_addr = '0; m_instr = '0;
        #1;
        check("rst_valid", o_instr_valid, 0);
        check("rst_fault", o_fault, 0);
        check("rst_addr", o_instr_addr, 0);
        check("rst_instr", o_instr, 0);
        @(posedge clk);
        #1 check("rst_valid_held", o_instr_valid, 0);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 6)      return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
        else if (r < 8) return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        else if (r < 9) return 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
        else            return $urandom;
    endfunction

    initial begin
        clr_n = 1'b1;
        i_instr_req = 0; i_flush = 0; i_hold = 0; i_ld_en = 0;
        i_pc = '0; i_ld_addr = '0; i_ld_data = '0;
        tick = 0;
        m_valid = 0; m_fault = 0; m_addr = '0; m_instr = '0;
        clear_stim();

        #2 clr_n = 1'b0;
        #1;
        check("init_valid", o_instr_valid, 0);
        check("init_fault", o_fault, 0);
        check("init_addr", o_instr_addr, 0);
        check("init_instr", o_instr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        // Preload every word so the model knows all memory contents.
        for (int i = 0; i < DEPTH; i++) begin
            d_ld_en = 1; d_ld_addr = 32'(i * 4); d_ld_data = $urandom;
            step();
        end

        // Basic fetch with two-edge latency
        d_ld_en = 1; d_ld_addr = 32'h8; d_ld_data = 32'h00A00093; step();
        d_req = 1; d_pc = 32'h8; step();
        check("lat_e0_valid", o_instr_valid, 0);
        step();
        check("lat_e1_valid", o_instr_valid, 0);
        step();
        check("lat_e2_valid", o_instr_valid, 1);
        check("lat_e2_instr", o_instr, 32'h00A00093);
        check("lat_e2_addr", o_instr_addr, 32'h8);
        check("lat_e2_fault", o_fault, 0);

        // Back-to-back requests, no gaps
        d_req = 1; d_pc = 32'h0; step();
        d_req = 1; d_pc = 32'h4; step();
        d_req = 1; d_pc = 32'h8; step();
        check("b2b_0_valid", o_instr_valid, 1);
        check("b2b_0_addr", o_instr_addr, 32'h0);
        step();
        check("b2b_1_valid", o_instr_valid, 1);
        check("b2b_1_addr", o_instr_addr, 32'h4);
        step();
        check("b2b_2_valid", o_instr_valid, 1);
        check("b2b_2_addr", o_instr_addr, 32'h8);
        step();
        check("b2b_end_valid", o_instr_valid, 0);

        // Flush with a same-edge new request
        d_req = 1; d_pc = 32'h4; step();
        d_req = 1; d_pc = 32'h40; d_flush = 1; step();
        check("flush_e1_valid", o_instr_valid, 0);
        step();
        check("flush_e2_valid", o_instr_valid, 0);
        step();
        check("flush_e3_valid", o_instr_valid, 1);
        check("flush_e3_addr", o_instr_addr, 32'h40);

        // Misaligned and out-of-range faults
        d_req = 1; d_pc = 32'h6; step();
        d_req = 1; d_pc = 32'(DEPTH * 4); step();
        step();
        check("mis_valid", o_instr_valid, 1);
        check("mis_addr", o_instr_addr, 32'h6);
        check("mis_fault", o_fault, 1);
        check("mis_instr", o_instr, 32'h00000013);
        step();
        check("oor_valid", o_instr_valid, 1);
        check("oor_addr", o_instr_addr, 32'h400);
        check("oor_fault", o_fault, 1);
        check("oor_instr", o_instr, 32'h00000013);

        // Hold for three cycles with one request in flight
        d_req = 1; d_pc = 32'h10; step();
        for (int i = 0; i < 3; i++) begin
            d_hold = 1; d_req = 1; d_pc = 32'h20; step();
            check("hold_stall", o_stall, 1);
            check("hold_valid", o_instr_valid, 0);
        end
        step();
        check("hold_e4_valid", o_instr_valid, 0);
        step();
        check("hold_e5_valid", o_instr_valid, 1);
        check("hold_e5_addr", o_instr_addr, 32'h10);
        step();
        check("hold_e6_valid", o_instr_valid, 0);
        step();
        check("hold_e7_valid", o_instr_valid, 0);

        // Read and write to the same word on one edge returns old data
        d_ld_en = 1; d_ld_addr = 32'h20; d_ld_data = 32'h11111111; step();
        d_req = 1; d_pc = 32'h20; step();
        step();
        d_ld_en = 1; d_ld_addr = 32'h20; d_ld_data = 32'h22222222; step();
        check("rdw_old_instr", o_instr, 32'h11111111);
        d_req = 1; d_pc = 32'h20; step();
        step();
        step();
        check("rdw_new_instr", o_instr, 32'h22222222);

        // Reset between request and response
        d_req = 1; d_pc = 32'h18; step();
        step();
        step();
        check("pre_rst_addr", o_instr_addr, 32'h18);
        d_req = 1; d_pc = 32'h14; step();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", o_instr_valid, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            d_req     = ($urandom_range(0, 9) < 7);
            d_pc      = rand_addr();
            d_flush   = ($urandom_range(0, 19) == 0);
            d_hold    = ($urandom_range(0, 6) == 0);
            d_ld_en   = ($urandom_range(0, 4) == 0);
            d_ld_addr = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].addr : rand_addr();
            d_ld_data = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
